led_mode_ctrl: RTL and testbench
================================

Name: led_mode_ctrl

Overview:
Front-panel LED sequencer. It debounces two raw active-low push keys and runs a 4-mode display state machine: OFF, ALL_ON, BLINK and CHASE. The key_mode key steps through the modes. The key_speed key toggles the animation rate between slow and fast. It sits between the board keys and the LED pins and drives the registered LED pattern directly.

Parameters:
LED_NUM, 4, number of LEDs driven (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a key level (20 ms at 50 MHz)
TICK_CYCLES, 25000000, animation tick period in slow rate (500 ms at 50 MHz); must be divisible by 4

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  reset, asynchronous assert, active-low
key_mode  input  1  raw mode key, active-low (0 = pressed), asynchronous to sys_clk
key_speed  input  1  raw speed key, active-low, asynchronous to sys_clk
led  output  LED_NUM  registered LED drive, active-high (1 = lit)
mode  output  2  current mode: 0 OFF, 1 ALL_ON, 2 BLINK, 3 CHASE
fast  output  1  1 = fast rate (tick period TICK_CYCLES/4)

Behaviour:
Interface:
- One clock, sys_clk. Reset sys_rst_n is asynchronous and active-low; all flops clear immediately on assertion.

Reset values:
- led = 0, mode = 0 (OFF), fast = 0.
- Synchronizers = 1, debounced levels = 1 (released), debounce counters = 0.
- Tick counter = 0, blink phase = 0, chase vector = one-hot bit 0.

Key input path (per key, identical):
- Two-flop synchronizer.
- Debounce counter increments while the synchronized level differs from the debounced level. It clears to 0 on any cycle where the two are equal.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized level in that same cycle and the counter clears.
- A press event is a one-cycle registered pulse on a debounced 1->0 transition. Release generates nothing.

Latency:
- First edge sampling key low = edge 0. Debounced level falls at edge DEBOUNCE_CYCLES+1. Press pulse is high after edge DEBOUNCE_CYCLES+2.
- mode/fast update at edge DEBOUNCE_CYCLES+3. led reflects the new state at edge DEBOUNCE_CYCLES+4.

Mode FSM:
- A mode press advances OFF->ALL_ON->BLINK->CHASE->OFF (2-bit wrap).
- Any mode change clears the tick counter, sets blink phase = 0 and sets chase = bit 0.

Speed:
- A speed press toggles fast.
- The tick counter clears on a toggle. There is no other state change.

Simultaneous press pulses:
- Both actions apply in the same cycle.
- Tick counter clears once.

Tick counter:
- Limit = TICK_CYCLES-1 (slow) or TICK_CYCLES/4-1 (fast).
- Counts 0..limit and wraps to 0.
- tick is asserted for the single cycle in which count == limit.
- If fast toggles while count > new limit, the clear on toggle prevents overrun.

LED output (registered, one cycle after state):
- OFF: all 0.
- ALL_ON: all 1.
- BLINK: all LEDs = blink phase. The phase starts at 0 and toggles on every tick.
- CHASE: led = chase vector. It rotates left by 1 on every tick; the MSB wraps to bit 0.
- In OFF and ALL_ON the tick counter keeps running, but phase and chase are held.

Glitches:
- Key bounce shorter than DEBOUNCE_CYCLES produces no event.
- A key held indefinitely produces exactly one event.

Reset mid-operation:
- All state returns to reset values immediately.
- A key still held low after reset release produces one press event once debounced, because the debounced level resets to released.

Test Plan:
All scenarios use LED_NUM=4, DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
- Reset: assert sys_rst_n=0 mid-tick in CHASE, then release -> led=0000, mode=0 and fast=0 immediately; no event while keys are high.
- Single press: key_mode low from edge 0 and held -> mode=1 after edge 7, led=1111 after edge 8; no further change while held; release gives no event.
- Bounce: key_mode low 3 cycles, high 1 cycle, repeated 5 times -> mode stays 0 throughout; a following clean 6-cycle low -> mode=1.
- Blink: press mode twice from reset (BLINK) -> led=0000, then toggles 1111/0000 every 8 cycles; press key_speed -> fast=1, toggle period becomes 2 cycles, with the first toggle 2 cycles after the fast update.
- Chase wrap: enter CHASE at slow rate -> led sequence 0001, 0010, 0100, 1000, 0001 at 8-cycle spacing; mode press -> OFF, led=0000; three more presses return to CHASE starting at 0001.
- Simultaneous: key_mode and key_speed fall on the same edge -> after edge 7, mode increments by 1 and fast toggles in the same cycle; tick counter = 0.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
//
// Front-panel LED sequencer. Two raw active-low push keys are synchronized
// and debounced. A press (debounced 1->0) produces a one-cycle pulse.
// The mode key steps OFF -> ALL_ON -> BLINK -> CHASE -> OFF.
// The speed key toggles the animation tick between slow and fast.
// The LED pattern is registered one cycle after the mode/animation state.
//
// Parameters:
//   LED_NUM          number of LEDs driven (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable cycles before a key level is accepted
//   TICK_CYCLES      slow tick period; the fast period is TICK_CYCLES/4
//
// Ports:
//   sys_clk    input              system clock
//   sys_rst_n  input              asynchronous active-low reset
//   key_mode   input              raw mode key, active-low, asynchronous
//   key_speed  input              raw speed key, active-low, asynchronous
//   led        output [LED_NUM]   registered LED drive, 1 = lit
//   mode       output [2]         0 OFF, 1 ALL_ON, 2 BLINK, 3 CHASE
//   fast       output             1 = fast animation rate
// ---------------------------------------------------------------------------
module led_mode_ctrl #(
  parameter int LED_NUM         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 25000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               key_mode,
  input  logic               key_speed,
  output logic [LED_NUM-1:0] led,
  output logic [1:0]         mode,
  output logic               fast
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALL_ON = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  localparam int KEYS    = 2;
  localparam int KEY_MODE_IDX  = 0;
  localparam int KEY_SPEED_IDX = 1;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int TK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TK_W-1:0] SLOW_LIMIT = TK_W'(TICK_CYCLES - 1);
  localparam logic [TK_W-1:0] FAST_LIMIT = TK_W'(TICK_CYCLES / 4 - 1);

  localparam logic [LED_NUM-1:0] CHASE_INIT = LED_NUM'(1);

  // -------------------------------------------------------------------------
  // Key input path
  // -------------------------------------------------------------------------
  logic [KEYS-1:0] keyRaw;
  logic [KEYS-1:0] sync1_q;
  logic [KEYS-1:0] sync2_q;
  logic [KEYS-1:0] level_q;
  logic [KEYS-1:0] level_d;
  logic [KEYS-1:0] levelDly_q;
  logic [KEYS-1:0] press_q;
  logic [DB_W-1:0] dbCnt_q [KEYS];
  logic [DB_W-1:0] dbCnt_d [KEYS];

  assign keyRaw = {key_speed, key_mode};

  // The counter only runs while the synchronized level disagrees with the
  // accepted level; any agreeing cycle restarts the count, so a bounce
  // shorter than DEBOUNCE_CYCLES never reaches the accept point.
  always_comb begin
    level_d = level_q;
    for (int k = 0; k < KEYS; k++) begin
      dbCnt_d[k] = '0;
      if (sync2_q[k] != level_q[k]) begin
        if (dbCnt_q[k] == DB_LAST) begin
          level_d[k] = sync2_q[k];
        end else begin
          dbCnt_d[k] = dbCnt_q[k] + DB_W'(1);
        end
      end
    end
  end

  // Released (1) is the reset level so a key held through reset still
  // yields exactly one press after it is debounced. The press pulse is taken
  // from the registered level and its delayed copy, so it is itself a flop.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      level_q    <= '1;
      levelDly_q <= '1;
      press_q    <= '0;
      for (int k = 0; k < KEYS; k++) begin
        dbCnt_q[k] <= '0;
      end
    end else begin
      sync1_q    <= keyRaw;
      sync2_q    <= sync1_q;
      level_q    <= level_d;
      levelDly_q <= level_q;
      press_q    <= levelDly_q & ~level_q;
      for (int k = 0; k < KEYS; k++) begin
        dbCnt_q[k] <= dbCnt_d[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Mode FSM, rate, tick counter and animation state
  // -------------------------------------------------------------------------
  mode_e               mode_q, mode_d;
  logic                fast_q, fast_d;
  logic [TK_W-1:0]     tickCnt_q, tickCnt_d;
  logic                phase_q, phase_d;
  logic [LED_NUM-1:0]  chase_q, chase_d;
  logic [LED_NUM-1:0]  led_q, led_d;
  logic [TK_W-1:0]     tickLimit;
  logic                tick;
  logic                modePress;
  logic                speedPress;

  assign modePress  = press_q[KEY_MODE_IDX];
  assign speedPress = press_q[KEY_SPEED_IDX];

  // Later assignments win: a mode change overrides both the tick update and
  // the speed-toggle clear, and a simultaneous speed press still flips the
  // rate in the same cycle. The counter is cleared whenever either press
  // lands, which also keeps it from running past a freshly shortened limit.
  always_comb begin
    tickLimit = fast_q ? FAST_LIMIT : SLOW_LIMIT;
    tick      = (tickCnt_q == tickLimit);

    mode_d    = mode_q;
    fast_d    = fast_q;
    phase_d   = phase_q;
    chase_d   = chase_q;
    tickCnt_d = tick ? '0 : tickCnt_q + TK_W'(1);

    if (tick) begin
      case (mode_q)
        MODE_BLINK: phase_d = ~phase_q;
        MODE_CHASE: chase_d = {chase_q[LED_NUM-2:0], chase_q[LED_NUM-1]};
        default:    ;
      endcase
    end

    if (speedPress) begin
      fast_d    = ~fast_q;
      tickCnt_d = '0;
    end

    if (modePress) begin
      case (mode_q)
        MODE_OFF:    mode_d = MODE_ALL_ON;
        MODE_ALL_ON: mode_d = MODE_BLINK;
        MODE_BLINK:  mode_d = MODE_CHASE;
        default:     mode_d = MODE_OFF;
      endcase
      tickCnt_d = '0;
      phase_d   = 1'b0;
      chase_d   = CHASE_INIT;
    end

    case (mode_q)
      MODE_OFF:    led_d = '0;
      MODE_ALL_ON: led_d = '1;
      MODE_BLINK:  led_d = {LED_NUM{phase_q}};
      default:     led_d = chase_q;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q    <= MODE_OFF;
      fast_q    <= 1'b0;
      tickCnt_q <= '0;
      phase_q   <= 1'b0;
      chase_q   <= CHASE_INIT;
      led_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      fast_q    <= fast_d;
      tickCnt_q <= tickCnt_d;
      phase_q   <= phase_d;
      chase_q   <= chase_d;
      led_q     <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign fast = fast_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_led_mode_ctrl
//
// Directed bench for led_mode_ctrl with LED_NUM=4, DEBOUNCE_CYCLES=4,
// TICK_CYCLES=8. Stimulus pushes hand-computed expectations tagged with the
// clock edge count at which they must hold; a monitor pops them on the
// falling edge and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_led_mode_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       key_mode;
  logic       key_speed;
  logic [3:0] led;
  logic [1:0] mode;
  logic       fast;

  int edgeCnt   = 0;
  int numChecks = 0;
  int numFails  = 0;

  typedef struct {
    int         cyc;
    logic [3:0] led;
    logic       chkLed;
    logic [1:0] mode;
    logic       fast;
    string      name;
  } exp_t;

  exp_t expQ[$];

  led_mode_ctrl #(
    .LED_NUM        (4),
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_mode (key_mode),
    .key_speed(key_speed),
    .led      (led),
    .mode     (mode),
    .fast     (fast)
  );

  // Free-running clock and a count of rising edges used as the time base
  // for every expectation.
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) edgeCnt <= edgeCnt + 1;

  // Hard stop in case the stimulus or drain ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, pending=%0d", expQ.size());
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitEdges(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic km, input logic ks);
    key_mode  = km;
    key_speed = ks;
  endtask

  // Insert keeping the queue ordered by edge so the monitor only ever
  // inspects the head.
  task automatic pushExpect(input int cyc, input logic [3:0] ledV, input logic chkLed,
                            input logic [1:0] modeV, input logic fastV, input string name);
    exp_t e;
    int   idx;
    e.cyc    = cyc;
    e.led    = ledV;
    e.chkLed = chkLed;
    e.mode   = modeV;
    e.fast   = fastV;
    e.name   = name;
    idx = expQ.size();
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].cyc > cyc) begin
        idx = i;
        break;
      end
    end
    expQ.insert(idx, e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic ok;
    numChecks++;
    ok = (mode === e.mode) && (fast === e.fast) && (!e.chkLed || (led === e.led));
    if (!ok) begin
      numFails++;
      $display("[TB] FAIL %s @edge %0d: got led=%b mode=%0d fast=%b, want led=%b%s mode=%0d fast=%b",
               e.name, e.cyc, led, mode, fast, e.led, e.chkLed ? "" : "(ignored)", e.mode, e.fast);
    end
  endtask

  // Monitor: compares every expectation due at the current edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge sys_clk);
      while (expQ.size() > 0 && expQ[0].cyc <= edgeCnt) begin
        e = expQ.pop_front();
        if (e.cyc < edgeCnt) begin
          numChecks++;
          numFails++;
          $display("[TB] FAIL %s: due at edge %0d but seen at edge %0d", e.name, e.cyc, edgeCnt);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  initial begin : stimulus
    int e;
    int mEdge;
    int sEdge;
    int fEdge;
    int cEdge;
    int guard;
    logic [3:0] ledAfter [3];
    exp_t left;

    ledAfter[0] = 4'b1111;
    ledAfter[1] = 4'b0000;
    ledAfter[2] = 4'b0001;

    // Reset
    sys_rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1);
    waitEdges(3);
    pushExpect(edgeCnt, 4'b0000, 1'b1, 2'd0, 1'b0, "reset_hold");
    waitEdges(1);
    sys_rst_n = 1'b1;
    waitEdges(20);
    pushExpect(edgeCnt, 4'b0000, 1'b1, 2'd0, 1'b0, "idle_no_event");
    $display("[TB] reset checks queued");

    // Single press held: mode after edge 7, led after edge 8
    e = edgeCnt;
    applyStimulus(1'b0, 1'b1);
    pushExpect(e + 7, 4'b0000, 1'b1, 2'd0, 1'b0, "press_before");
    pushExpect(e + 8, 4'b0000, 1'b1, 2'd1, 1'b0, "press_mode");
    pushExpect(e + 9, 4'b1111, 1'b1, 2'd1, 1'b0, "press_led");
    waitEdges(20);
    pushExpect(edgeCnt, 4'b1111, 1'b1, 2'd1, 1'b0, "press_held");
    applyStimulus(1'b1, 1'b1);
    waitEdges(15);
    pushExpect(edgeCnt, 4'b1111, 1'b1, 2'd1, 1'b0, "release_quiet");

    // Bounce: 3 low / 1 high, five times, no event
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1);
      waitEdges(3);
      applyStimulus(1'b1, 1'b1);
      waitEdges(1);
      pushExpect(edgeCnt, 4'b1111, 1'b1, 2'd1, 1'b0, "bounce_no_event");
    end

    // Clean 6-cycle press into BLINK, slow blink at 8-cycle spacing
    e = edgeCnt;
    mEdge = e + 8;
    applyStimulus(1'b0, 1'b1);
    pushExpect(e + 7,      4'b1111, 1'b1, 2'd1, 1'b0, "clean_before");
    pushExpect(mEdge,      4'b1111, 1'b1, 2'd2, 1'b0, "clean_mode");
    pushExpect(mEdge + 1,  4'b0000, 1'b1, 2'd2, 1'b0, "blink_start");
    pushExpect(mEdge + 8,  4'b0000, 1'b1, 2'd2, 1'b0, "blink_hold");
    pushExpect(mEdge + 9,  4'b1111, 1'b1, 2'd2, 1'b0, "blink_on");
    pushExpect(mEdge + 16, 4'b1111, 1'b1, 2'd2, 1'b0, "blink_on_hold");
    pushExpect(mEdge + 17, 4'b0000, 1'b1, 2'd2, 1'b0, "blink_off");
    pushExpect(mEdge + 25, 4'b1111, 1'b1, 2'd2, 1'b0, "blink_on2");
    waitEdges(6);
    applyStimulus(1'b1, 1'b1);

    // Speed press lands 3 edges after a blink toggle; fast period is 2
    waitEdges(mEdge + 19 - edgeCnt);
    sEdge = edgeCnt;
    fEdge = sEdge + 8;
    applyStimulus(1'b1, 1'b0);
    pushExpect(fEdge - 1, 4'b1111, 1'b1, 2'd2, 1'b0, "speed_before");
    pushExpect(fEdge,     4'b1111, 1'b1, 2'd2, 1'b1, "speed_fast");
    pushExpect(fEdge + 2, 4'b1111, 1'b1, 2'd2, 1'b1, "fast_hold");
    pushExpect(fEdge + 3, 4'b0000, 1'b1, 2'd2, 1'b1, "fast_toggle1");
    pushExpect(fEdge + 4, 4'b0000, 1'b1, 2'd2, 1'b1, "fast_hold2");
    pushExpect(fEdge + 5, 4'b1111, 1'b1, 2'd2, 1'b1, "fast_toggle2");
    pushExpect(fEdge + 7, 4'b0000, 1'b1, 2'd2, 1'b1, "fast_toggle3");
    waitEdges(10);
    applyStimulus(1'b1, 1'b1);
    waitEdges(12);

    // Simultaneous presses: BLINK->CHASE and fast->slow on the same edge
    e = edgeCnt;
    cEdge = e + 8;
    applyStimulus(1'b0, 1'b0);
    pushExpect(cEdge - 1,  4'b0000, 1'b0, 2'd2, 1'b1, "simul_before");
    pushExpect(cEdge,      4'b0000, 1'b0, 2'd3, 1'b0, "simul_both");
    pushExpect(cEdge + 1,  4'b0001, 1'b1, 2'd3, 1'b0, "chase_0");
    pushExpect(cEdge + 8,  4'b0001, 1'b1, 2'd3, 1'b0, "chase_0_hold");
    pushExpect(cEdge + 9,  4'b0010, 1'b1, 2'd3, 1'b0, "chase_1");
    pushExpect(cEdge + 17, 4'b0100, 1'b1, 2'd3, 1'b0, "chase_2");
    pushExpect(cEdge + 25, 4'b1000, 1'b1, 2'd3, 1'b0, "chase_3");
    pushExpect(cEdge + 33, 4'b0001, 1'b1, 2'd3, 1'b0, "chase_wrap");
    waitEdges(10);
    applyStimulus(1'b1, 1'b1);
    waitEdges(cEdge + 34 - edgeCnt);

    // CHASE -> OFF
    e = edgeCnt;
    applyStimulus(1'b0, 1'b1);
    pushExpect(e + 8, 4'b0000, 1'b0, 2'd0, 1'b0, "off_mode");
    pushExpect(e + 9, 4'b0000, 1'b1, 2'd0, 1'b0, "off_led");
    waitEdges(10);
    applyStimulus(1'b1, 1'b1);
    waitEdges(10);

    // Three more presses return to CHASE starting at bit 0
    for (int i = 0; i < 3; i++) begin
      e = edgeCnt;
      applyStimulus(1'b0, 1'b1);
      pushExpect(e + 8, 4'b0000, 1'b0, 2'(i + 1), 1'b0, "cycle_mode");
      pushExpect(e + 9, ledAfter[i], 1'b1, 2'(i + 1), 1'b0, "cycle_led");
      if (i == 2) begin
        pushExpect(e + 17, 4'b0010, 1'b1, 2'd3, 1'b0, "rechase_1");
      end
      waitEdges(10);
      applyStimulus(1'b1, 1'b1);
      waitEdges(10);
    end

    // Reset mid-tick in CHASE: outputs clear before any clock edge
    sys_rst_n = 1'b0;
    pushExpect(edgeCnt, 4'b0000, 1'b1, 2'd0, 1'b0, "reset_async");
    waitEdges(3);
    sys_rst_n = 1'b1;
    waitEdges(20);
    pushExpect(edgeCnt, 4'b0000, 1'b1, 2'd0, 1'b0, "reset_idle");

    // Drain pending expectations within a bounded number of cycles
    guard = 0;
    while (expQ.size() > 0 && guard < 200) begin
      @(posedge sys_clk);
      guard++;
    end
    while (expQ.size() > 0) begin
      left = expQ.pop_front();
      numChecks++;
      numFails++;
      $display("[TB] FAIL %s: never compared (due edge %0d, now %0d)", left.name, left.cyc, edgeCnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
